// File: rtl/vga_pkg.sv
// Shared VGA definitions: 800x600 timing, RGB 3-3-2 field widths, sync polarity,
// and the sync-pipeline record used by the sprite display.
package vga_pkg;

  localparam int VGA_H_TOTAL  = 1056;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_START  = 216;
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_V_TOTAL  = 628;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_START  = 27;
  localparam int VGA_V_ACTIVE = 600;

  localparam int RGB_R_W = 3;
  localparam int RGB_G_W = 3;
  localparam int RGB_B_W = 2;

  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic fstart;
  } sync_t;

  localparam sync_t SYNC_RESET = '{hsync: SYNC_IDLE, vsync: SYNC_IDLE, de: 1'b0, fstart: 1'b0};

  // One bounce step along an axis: returns {negative_dir, new_pos}.
  function automatic logic [32:0] bounce_step(input logic [31:0] pos,
                                              input logic [31:0] lim,
                                              input logic        neg);
    logic [31:0] nxt;
    logic        nneg;
    nxt  = pos;
    nneg = neg;
    if (lim == 32'd0) begin
      nxt  = 32'd0;
      nneg = 1'b0;
    end else if (!neg) begin
      if (pos >= lim) begin
        nxt  = lim - 32'd1;
        nneg = 1'b1;
      end else begin
        nxt  = pos + 32'd1;
        nneg = (nxt == lim);
      end
    end else begin
      if (pos == 32'd0) begin
        nxt  = 32'd1;
        nneg = 1'b0;
      end else begin
        nxt  = pos - 32'd1;
        nneg = (nxt != 32'd0);
      end
    end
    return {nneg, nxt};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA raster counters with raw (undelayed) sync, data-enable and
// frame boundary flags; reusable by any pixel pipeline.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_START  = VGA_H_START,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_START  = VGA_V_START,
  parameter int V_ACTIVE = VGA_V_ACTIVE
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic [$clog2(H_TOTAL)-1:0] h_cnt_o,
  output logic [$clog2(V_TOTAL)-1:0] v_cnt_o,
  output logic                       hsync_o,
  output logic                       vsync_o,
  output logic                       de_o,
  output logic                       frame_first_o,
  output logic                       frame_last_o
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_end, v_end;

  assign h_end = (h_cnt_q == HW'(H_TOTAL - 1));
  assign v_end = (v_cnt_q == VW'(V_TOTAL - 1));

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_end) begin
      h_cnt_d = '0;
      v_cnt_d = v_end ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Comparisons are done at 32 bits so H_START+H_ACTIVE may equal H_TOTAL safely.
  assign hsync_o = (32'(h_cnt_q) < H_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
  assign vsync_o = (32'(v_cnt_q) < V_SYNC) ? SYNC_ACTIVE : SYNC_IDLE;
  assign de_o    = (32'(h_cnt_q) >= H_START) && (32'(h_cnt_q) < H_START + H_ACTIVE) &&
                   (32'(v_cnt_q) >= V_START) && (32'(v_cnt_q) < V_START + V_ACTIVE);

  assign frame_first_o = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_last_o  = h_end && v_end;
  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;

endmodule

// File: rtl/vga_sprite_display.sv
// Sprite overlay on a VGA raster: window/ROM addressing, tear-free position update
// and ROM-latency alignment. Optional macro VGA_SPRITE_BOUNCE_EN adds auto-bounce.
module vga_sprite_display
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_START  = VGA_H_START,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_START  = VGA_V_START,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int IMG_W    = 100,
  parameter int IMG_H    = 150,
  parameter int RGB_W    = 8,
  parameter int ADDR_W   = 15,
  parameter int ROM_LAT  = 1,
  parameter int INIT_X   = 385,
  parameter int INIT_Y   = 224
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_we,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]  rom_dout,
  output logic [RGB_W-1:0]  rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  localparam int          HW    = $clog2(H_TOTAL);
  localparam int          VW    = $clog2(V_TOTAL);
  localparam logic [10:0] X_LIM = 11'(H_ACTIVE - IMG_W);
  localparam logic [9:0]  Y_LIM = 10'(V_ACTIVE - IMG_H);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          hs_raw, vs_raw, de_raw, frame_first, frame_last;

  vga_timing #(
    .H_TOTAL (H_TOTAL),
    .H_SYNC  (H_SYNC),
    .H_START (H_START),
    .H_ACTIVE(H_ACTIVE),
    .V_TOTAL (V_TOTAL),
    .V_SYNC  (V_SYNC),
    .V_START (V_START),
    .V_ACTIVE(V_ACTIVE)
  ) u_timing (
    .clk_i        (clk),
    .rst_i        (rst),
    .h_cnt_o      (h_cnt),
    .v_cnt_o      (v_cnt),
    .hsync_o      (hs_raw),
    .vsync_o      (vs_raw),
    .de_o         (de_raw),
    .frame_first_o(frame_first),
    .frame_last_o (frame_last)
  );

  // Position: pending is written by pos_we, current is what the raster uses.
  logic [10:0] pend_x_q, pend_x_d, cur_x_q, cur_x_d;
  logic [9:0]  pend_y_q, pend_y_d, cur_y_q, cur_y_d;
`ifdef VGA_SPRITE_BOUNCE_EN
  dir_e        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [32:0] step_x, step_y;
`endif

  always_comb begin
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
`ifdef VGA_SPRITE_BOUNCE_EN
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    step_x  = bounce_step(32'(pend_x_q), 32'(X_LIM), dir_x_q == DIR_NEG);
    step_y  = bounce_step(32'(pend_y_q), 32'(Y_LIM), dir_y_q == DIR_NEG);
    if (frame_last) begin
      cur_x_d  = 11'(step_x[31:0]);
      cur_y_d  = 10'(step_y[31:0]);
      pend_x_d = 11'(step_x[31:0]);
      pend_y_d = 10'(step_y[31:0]);
      dir_x_d  = step_x[32] ? DIR_NEG : DIR_POS;
      dir_y_d  = step_y[32] ? DIR_NEG : DIR_POS;
    end
`else
    if (frame_last) begin
      cur_x_d = pend_x_q;
      cur_y_d = pend_y_q;
    end
`endif
    // A strobe in the transfer cycle lands in pending only and shows next frame.
    if (pos_we) begin
      pend_x_d = (pos_x > X_LIM) ? X_LIM : pos_x;
      pend_y_d = (pos_y > Y_LIM) ? Y_LIM : pos_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_x_q <= 11'(INIT_X);
      pend_y_q <= 10'(INIT_Y);
      cur_x_q  <= 11'(INIT_X);
      cur_y_q  <= 10'(INIT_Y);
`ifdef VGA_SPRITE_BOUNCE_EN
      dir_x_q  <= DIR_POS;
      dir_y_q  <= DIR_POS;
`endif
    end else begin
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
`ifdef VGA_SPRITE_BOUNCE_EN
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
`endif
    end
  end

  logic [31:0] x_lo, y_lo;
  logic        in_x, in_y, win_raw;

  assign x_lo    = 32'(H_START) + 32'(cur_x_q);
  assign y_lo    = 32'(V_START) + 32'(cur_y_q);
  assign in_x    = (32'(h_cnt) >= x_lo) && (32'(h_cnt) < x_lo + 32'(IMG_W));
  assign in_y    = (32'(v_cnt) >= y_lo) && (32'(v_cnt) < y_lo + 32'(IMG_H));
  assign win_raw = de_raw && in_x && in_y;

  // Window flag delayed ROM_LAT cycles so it lines up with rom_dout.
  logic win_lat;
  if (ROM_LAT == 0) begin : g_win_direct
    assign win_lat = win_raw;
  end else begin : g_win_pipe
    logic [ROM_LAT-1:0] win_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        win_q <= '0;
      end else begin
        win_q[0] <= win_raw;
        for (int i = 1; i < ROM_LAT; i++) win_q[i] <= win_q[i-1];
      end
    end
    assign win_lat = win_q[ROM_LAT-1];
  end

  sync_t sync_raw;
  sync_t sync_q [ROM_LAT+1];

  assign sync_raw = '{hsync: hs_raw, vsync: vs_raw, de: de_raw, fstart: frame_first};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= ROM_LAT; i++) sync_q[i] <= SYNC_RESET;
    end else begin
      sync_q[0] <= sync_raw;
      for (int i = 1; i <= ROM_LAT; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // rom_addr holds the address of the pixel the counters point at right now.
  logic [ADDR_W-1:0] rom_addr_q;
  logic [RGB_W-1:0]  rgb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      rgb_q      <= '0;
    end else begin
      if (frame_last) begin
        rom_addr_q <= '0;
      end else if (win_raw) begin
        rom_addr_q <= rom_addr_q + 1'b1;
      end
      rgb_q <= win_lat ? rom_dout : '0;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign rgb         = rgb_q;
  assign hsync       = sync_q[ROM_LAT].hsync;
  assign vsync       = sync_q[ROM_LAT].vsync;
  assign de          = sync_q[ROM_LAT].de;
  assign frame_start = sync_q[ROM_LAT].fstart;

endmodule
